// File: rtl/key_mode_ctrl.sv
// -----------------------------------------------------------------------------
// key_mode_ctrl
//
// Conditions the two raw active-low pushbuttons that drive the pulse
// generator: a start key and a mode-advance key. Each button is synchronised,
// debounced, and fed to a small press-detect FSM. The start button produces a
// debounced level plus a press strobe; the mode button steps a registered
// mode selector, except while the start key is held down.
//
// Ports
//   clk        system clock (50 MHz), rising edge
//   reset      synchronous reset, active low
//   key_raw    raw start button, active low, asynchronous to clk
//   mode_raw   raw mode-advance button, active low, asynchronous to clk
//   key        debounced start level, active low
//   mode_sel   current mode, 0..NUM_MODES-1
//   key_press  one-cycle strobe on an accepted start press
//   mode_chg   one-cycle strobe when mode_sel advances
//
// FSM states (one instance per button)
//   state   | meaning
//   IDLE    | debounced level is high, waiting for a press
//   PRESSED | debounced level is low, waiting for release (no repeat strobes)
// -----------------------------------------------------------------------------
module key_mode_ctrl #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int NUM_MODES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_raw,
  input  logic       mode_raw,
  output logic       key,
  output logic [2:0] mode_sel,
  output logic       key_press,
  output logic       mode_chg
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [2:0]    MODE_LAST = 3'(NUM_MODES - 1);

  // Channel 0 is the start key, channel 1 the mode key.
  localparam int CH_KEY  = 0;
  localparam int CH_MODE = 1;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } btn_state_t;

  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    db;
  logic [CW-1:0] cnt [2];
  logic [1:0]    accept;

  btn_state_t key_st;
  btn_state_t mode_st;

  logic key_fall;
  logic key_rise;
  logic mode_fall;
  logic mode_rise;

  assign raw = {mode_raw, key_raw};

  // A new level is accepted on the edge where the disagreement has already
  // lasted DB_CYCLES-1 counts and still holds, so the debounced level moves
  // exactly DB_CYCLES edges after the synchronised input first differs.
  always_comb begin
    accept = '0;
    for (int i = 0; i < 2; i++) begin
      accept[i] = (sync2[i] != db[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
      db    <= '1;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Edge events happen on the same clock edge as the debounced level update,
  // which lets the strobes line up with the key transition.
  assign key_fall  = accept[CH_KEY]  && !sync2[CH_KEY];
  assign key_rise  = accept[CH_KEY]  &&  sync2[CH_KEY];
  assign mode_fall = accept[CH_MODE] && !sync2[CH_MODE];
  assign mode_rise = accept[CH_MODE] &&  sync2[CH_MODE];

  assign key = db[CH_KEY];

  always_ff @(posedge clk) begin
    if (!reset) begin
      key_st    <= IDLE;
      mode_st   <= IDLE;
      key_press <= 1'b0;
      mode_chg  <= 1'b0;
      mode_sel  <= 3'd0;
    end else begin
      key_press <= 1'b0;
      mode_chg  <= 1'b0;

      case (key_st)
        IDLE: begin
          if (key_fall) begin
            key_st    <= PRESSED;
            key_press <= 1'b1;
          end
        end
        PRESSED: begin
          if (key_rise) begin
            key_st <= IDLE;
          end
        end
        default: key_st <= IDLE;
      endcase

      case (mode_st)
        IDLE: begin
          if (mode_fall) begin
            mode_st <= PRESSED;
            // Pre-edge key level: a mode press landing on the same edge as a
            // start press still counts, but one made while the start key is
            // already down is swallowed so the mode stays frozen mid-run.
            if (key) begin
              mode_chg <= 1'b1;
              if (mode_sel == MODE_LAST) begin
                mode_sel <= 3'd0;
              end else begin
                mode_sel <= mode_sel + 3'd1;
              end
            end
          end
        end
        PRESSED: begin
          if (mode_rise) begin
            mode_st <= IDLE;
          end
        end
        default: mode_st <= IDLE;
      endcase
    end
  end

endmodule
